// File: rtl/nlp_update_queue.sv
// nlp_update_queue
//
// Purpose:
//   Buffers resolved branch outcomes from the backend and replays them, one
//   per cycle, onto the next-line predictor update port (BHT + uBTB). Bursts
//   of resolutions are absorbed in a circular FIFO and metered out at one
//   update per unheld cycle. When the FIFO is empty and the frontend is not
//   holding, an accepted resolution skips the FIFO and goes straight into
//   the output register.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   res_valid / res_ready         backend handshake; res_ready = (count != DEPTH)
//   res_pc, res_target, res_taken,
//   res_cut_pos, res_branch_type  resolved branch payload
//   upd_hold                      frontend asks for no update this cycle
//   update_valid, update_pc, target_pc, update_taken,
//   update_cut_pos, update_branch_type
//                                 registered NLP update strobe and payload
//   count                         FIFO occupancy (output register excluded)
//
// Configuration:
//   NLP_UPQ_COALESCE_EN  when defined, a resolution whose pc[31:4] and other
//                        fields match the most recently written FIFO entry is
//                        accepted but not stored. Undefined by default.

module nlp_update_queue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [31:0]      res_pc,
  input  logic [31:0]      res_target,
  input  logic             res_taken,
  input  logic [1:0]       res_cut_pos,
  input  logic [1:0]       res_branch_type,
  input  logic             upd_hold,
  output logic             update_valid,
  output logic [31:0]      update_pc,
  output logic [31:0]      target_pc,
  output logic             update_taken,
  output logic [1:0]       update_cut_pos,
  output logic [1:0]       update_branch_type,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic [1:0]  cut_pos;
    logic [1:0]  branch_type;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;
  entry_t             out_q, out_d;

  entry_t res_entry;
  entry_t head_entry;
  logic   accept;
  logic   pop;
  logic   bypass;
  logic   push;
  logic   coalesce;

  assign res_entry  = '{pc: res_pc, target: res_target, taken: res_taken,
                        cut_pos: res_cut_pos, branch_type: res_branch_type};
  assign head_entry = mem_q[rd_ptr_q];

  // Ready depends only on registered occupancy, so a full queue stays
  // not-ready even in a cycle where the head is being popped.
  assign res_ready = (count_q != FULL_CNT);
  assign accept    = res_valid && res_ready;
  assign pop       = !upd_hold && (count_q != '0);
  assign bypass    = !upd_hold && (count_q == '0) && accept;

`ifdef NLP_UPQ_COALESCE_EN
  // Compare against the newest FIFO entry only; the output register and the
  // bypass path (count == 0) never take part. The entry may be popped in
  // this same cycle and the match still counts.
  entry_t last_entry;
  assign last_entry = mem_q[wr_ptr_q - PTR_W'(1)];
  assign coalesce   = accept && (count_q != '0)
                      && (res_pc[31:4]    == last_entry.pc[31:4])
                      && (res_target      == last_entry.target)
                      && (res_taken       == last_entry.taken)
                      && (res_cut_pos     == last_entry.cut_pos)
                      && (res_branch_type == last_entry.branch_type);
`else
  assign coalesce = 1'b0;
`endif

  assign push = accept && !bypass && !coalesce;

  // Next-state for pointers, occupancy and the output register. A pop takes
  // priority for the output register; bypass can only happen when the FIFO
  // is empty, so the two never compete.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = 1'b0;
    out_d    = out_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    if (pop) begin
      valid_d = 1'b1;
      out_d   = head_entry;
    end else if (bypass) begin
      valid_d = 1'b1;
      out_d   = res_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      out_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      out_q    <= out_d;
    end
  end

  // Storage array carries no reset; stale contents are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= res_entry;
    end
  end

  assign update_valid       = valid_q;
  assign update_pc          = out_q.pc;
  assign target_pc          = out_q.target;
  assign update_taken       = out_q.taken;
  assign update_cut_pos     = out_q.cut_pos;
  assign update_branch_type = out_q.branch_type;
  assign count              = count_q;

endmodule
